// File: rtl/spi_ram.sv
// Single-port byte memory behind an SPI slave: decodes 10-bit command words,
// keeps auto-incrementing write/read pointers and hands read bytes back for MISO.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    typedef enum logic {
        IDLE,
        TX_BUSY
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [8:0]           DEPTH_9   = 9'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    state_t               state, state_next;
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic                 wr_ok, rd_ok;
    logic [7:0]           mem [MEM_DEPTH];

    logic [1:0]           cmd;
    logic [7:0]           payload;
    logic                 addr_legal;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 reject;

    // Pointers wrap at MEM_DEPTH, not at the power of two above it.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    assign cmd        = din[9:8];
    assign payload    = din[7:0];
    assign addr_legal = ({1'b0, payload} < DEPTH_9);
    assign wr_accept  = rx_valid && (cmd == CMD_WR_DATA) && wr_ok;
    assign rd_accept  = rx_valid && (cmd == CMD_RD_DATA) && rd_ok;
    assign tx_valid   = (state == TX_BUSY);

    always_comb begin
        reject = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: reject = !addr_legal;
                CMD_WR_DATA: reject = !wr_ok;
                CMD_RD_ADDR: reject = !addr_legal;
                default:     reject = !rd_ok;
            endcase
        end
    end

    // Any consumed word ends the current transmit; only an accepted read re-arms it.
    always_comb begin
        state_next = state;
        if (rx_valid) begin
            state_next = rd_accept ? TX_BUSY : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_ok  <= 1'b0;
            rd_ok  <= 1'b0;
            err    <= 1'b0;
            dout   <= '0;
        end else begin
            err <= reject;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_ok <= addr_legal;
                        if (addr_legal) begin
                            wr_ptr <= payload[ADDR_SIZE-1:0];
                        end
                    end
                    CMD_WR_DATA: begin
                        if (wr_ok) begin
                            wr_ptr <= next_addr(wr_ptr);
                        end
                    end
                    CMD_RD_ADDR: begin
                        rd_ok <= addr_legal;
                        if (addr_legal) begin
                            rd_ptr <= payload[ADDR_SIZE-1:0];
                        end
                    end
                    default: begin
                        if (rd_ok) begin
                            dout   <= mem[rd_ptr];
                            rd_ptr <= next_addr(rd_ptr);
                        end
                    end
                endcase
            end
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= payload;
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a 256-deep instance for the main paths and a
// 200-deep instance for address range checks and non-power-of-two wrap.
module tb_spi_ram;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout_a, dout_b;
    logic       tx_valid_a, tx_valid_b;
    logic       err_a, err_b;

    int total;
    int bad;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout_a),
        .tx_valid (tx_valid_a),
        .err      (err_a)
    );

    spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout_b),
        .tx_valid (tx_valid_b),
        .err      (err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [1:0] c, input logic [7:0] p);
        din      = {c, p};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        din      = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout_a), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid_a), 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        rst_n = 1'b1;
        idle();

        // protocol errors straight after reset
        word(2'b01, 8'h33);
        chk("wdata_noaddr_err", 32'(err_a), 32'h1);
        idle();
        chk("err_one_cycle", 32'(err_a), 32'h0);
        word(2'b11, 8'h00);
        chk("rdata_noaddr_err", 32'(err_a), 32'h1);
        chk("rdata_noaddr_tv", 32'(tx_valid_a), 32'h0);
        chk("rdata_noaddr_dout", 32'(dout_a), 32'h00);
        idle();

        // burst write then burst read, back to back
        word(2'b00, 8'h10);
        chk("waddr_err", 32'(err_a), 32'h0);
        word(2'b01, 8'hA5);
        word(2'b01, 8'h5A);
        word(2'b10, 8'h10);
        chk("raddr_tv", 32'(tx_valid_a), 32'h0);
        word(2'b11, 8'hFF);
        chk("rd1_dout", 32'(dout_a), 32'hA5);
        chk("rd1_tv", 32'(tx_valid_a), 32'h1);
        word(2'b11, 8'h00);
        chk("rd2_dout", 32'(dout_a), 32'h5A);
        chk("rd2_tv", 32'(tx_valid_a), 32'h1);
        chk("rd2_err", 32'(err_a), 32'h0);

        // tx_valid held across idle cycles, released by next command
        for (int i = 0; i < 20; i++) begin
            idle();
            chk("hold_tv", 32'(tx_valid_a), 32'h1);
            chk("hold_dout", 32'(dout_a), 32'h5A);
        end
        word(2'b10, 8'h00);
        chk("release_tv", 32'(tx_valid_a), 32'h0);
        chk("release_err", 32'(err_a), 32'h0);
        idle();

        // pointer wrap at 0xFF -> 0x00
        word(2'b00, 8'hFF);
        word(2'b01, 8'h11);
        word(2'b01, 8'h22);
        word(2'b10, 8'hFF);
        word(2'b11, 8'h00);
        chk("wrap_rd1", 32'(dout_a), 32'h11);
        word(2'b11, 8'h00);
        chk("wrap_rd2", 32'(dout_a), 32'h22);
        chk("wrap_tv", 32'(tx_valid_a), 32'h1);
        idle();

        // read-after-write on consecutive edges
        word(2'b10, 8'h50);
        word(2'b00, 8'h50);
        word(2'b01, 8'h99);
        word(2'b11, 8'h00);
        chk("raw_dout", 32'(dout_a), 32'h99);
        idle();

        // 200-deep instance: range check and wrap at 199
        word(2'b00, 8'hC8);
        chk("b_waddr_illegal_err", 32'(err_b), 32'h1);
        chk("a_waddr_c8_err", 32'(err_a), 32'h0);
        word(2'b01, 8'h12);
        chk("b_wr_ok_cleared", 32'(err_b), 32'h1);
        word(2'b00, 8'hC7);
        chk("b_waddr_legal", 32'(err_b), 32'h0);
        word(2'b01, 8'h12);
        chk("b_wdata_ok", 32'(err_b), 32'h0);
        word(2'b01, 8'h34);
        word(2'b10, 8'hC7);
        word(2'b11, 8'h00);
        chk("b_rd_c7", 32'(dout_b), 32'h12);
        chk("b_rd_tv", 32'(tx_valid_b), 32'h1);
        word(2'b11, 8'h00);
        chk("b_rd_wrap", 32'(dout_b), 32'h34);
        word(2'b10, 8'hC8);
        chk("b_raddr_illegal_err", 32'(err_b), 32'h1);
        chk("b_raddr_illegal_tv", 32'(tx_valid_b), 32'h0);
        word(2'b11, 8'h00);
        chk("b_rd_ok_cleared", 32'(err_b), 32'h1);
        chk("b_rd_rejected_dout", 32'(dout_b), 32'h34);
        idle();

        // asynchronous reset while transmitting
        word(2'b10, 8'h10);
        word(2'b11, 8'h00);
        chk("pre_rst_dout", 32'(dout_a), 32'hA5);
        chk("pre_rst_tv", 32'(tx_valid_a), 32'h1);
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tv", 32'(tx_valid_a), 32'h0);
        chk("async_rst_dout", 32'(dout_a), 32'h00);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        word(2'b11, 8'h00);
        chk("post_rst_rd_err", 32'(err_a), 32'h1);
        chk("post_rst_rd_tv", 32'(tx_valid_a), 32'h0);
        idle();
        chk("post_rst_err_clear", 32'(err_a), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
